// File: rtl/fir_delay_line_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_delay_line_reader: circular sample delay line that streams all taps  |
// | newest-to-oldest to a serial MAC. Optional macro FIR_DL_FLUSH_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_delay_line_reader #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIR_DL_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [DATA_W-1:0] tap_data,
  output logic [ADDR_W-1:0] tap_index,
  output logic              tap_first,
  output logic              tap_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [TAPS];
  logic [ADDR_W-1:0] r_np;
  logic [ADDR_W-1:0] r_k;
  logic              r_tap_valid;
  logic [DATA_W-1:0] r_tap_data;
  logic [ADDR_W-1:0] r_tap_index;
  logic              r_tap_first;
  logic              r_tap_last;

  logic              w_flush;
  logic              w_accept;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_rd_addr;

`ifdef FIR_DL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Pointer arithmetic relies on the natural ADDR_W-bit wrap for modulo TAPS.
  assign w_wr_addr = r_np + c_one;
  assign w_rd_addr = r_np - r_k;
  assign w_accept  = (r_state == S_IDLE) && in_valid && !w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
      r_state     <= S_IDLE;
      r_np        <= '1;
      r_k         <= '0;
      r_tap_valid <= 1'b0;
      r_tap_data  <= '0;
      r_tap_index <= '0;
      r_tap_first <= 1'b0;
      r_tap_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush) begin
            for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
            r_np <= '1;
          end else if (w_accept) begin
            r_mem[w_wr_addr] <= in_data;
            r_np             <= w_wr_addr;
            r_k              <= '0;
            r_state          <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tap_data  <= r_mem[w_rd_addr];
          r_tap_valid <= 1'b1;
          r_tap_index <= '0;
          r_tap_first <= 1'b1;
          r_tap_last  <= (TAPS == 1);
          r_k         <= c_one;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          // Outputs hold while the MAC stalls; only a completed beat advances.
          if (r_tap_valid && tap_ready) begin
            if (r_tap_last) begin
              r_tap_valid <= 1'b0;
              r_tap_first <= 1'b0;
              r_tap_last  <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_tap_data  <= r_mem[w_rd_addr];
              r_tap_index <= r_k;
              r_tap_first <= 1'b0;
              r_tap_last  <= (r_k == c_last_k);
              r_k         <= r_k + c_one;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !w_flush;
  assign busy      = (r_state != S_IDLE);
  assign tap_valid = r_tap_valid;
  assign tap_data  = r_tap_data;
  assign tap_index = r_tap_index;
  assign tap_first = r_tap_first;
  assign tap_last  = r_tap_last;

endmodule
`default_nettype wire

// File: tb/tb_fir_delay_line_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_delay_line_reader: directed + randomized bench with a queue-based |
// | history model for fir_delay_line_reader.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_delay_line_reader;

  localparam int DATA_W = 16;
  localparam int TAPS   = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              tap_valid;
  logic              tap_ready = 1'b0;
  logic [DATA_W-1:0] tap_data;
  logic [ADDR_W-1:0] tap_index;
  logic              tap_first;
  logic              tap_last;
  logic              busy;
`ifdef FIR_DL_FLUSH_EN
  logic              flush = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Newest sample at the front; tap k is x[n-k], zero where nothing was written.
  logic [DATA_W-1:0] hist [$];
  logic [DATA_W-1:0] cap  [TAPS];

  fir_delay_line_reader #(.DATA_W(DATA_W), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef FIR_DL_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tap_valid (tap_valid),
    .tap_ready (tap_ready),
    .tap_data  (tap_data),
    .tap_index (tap_index),
    .tap_first (tap_first),
    .tap_last  (tap_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_tap(input int k);
    return (k < hist.size()) ? hist[k] : '0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tap_valid"}, 32'(tap_valid), 32'd0);
    chk({tag, "_tap_data"},  32'(tap_data),  32'd0);
    chk({tag, "_tap_index"}, 32'(tap_index), 32'd0);
    chk({tag, "_tap_first"}, 32'(tap_first), 32'd0);
    chk({tag, "_tap_last"},  32'(tap_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; tap_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    hist.delete();
  endtask

  // Runs one stream after the accept edge; edges counts posedges since that edge.
  task automatic collect(input int stall_idx, input int stall_len, input bit rnd_bp,
                         input int abort_idx);
    int  beat = 0, edges = 0, stalls = 0, stalled = 0;
    bit  done = 1'b0;
    bit  rdy;
    forever begin
      @(posedge clk); #1; edges++;
      if (edges > 4*TAPS + 50) begin
        chk("stream_timeout", 32'(edges), 32'(4*TAPS + 50));
        break;
      end
      if (done) begin
        chk("end_in_ready",  32'(in_ready),  32'd1);
        chk("end_busy",      32'(busy),      32'd0);
        chk("end_tap_valid", 32'(tap_valid), 32'd0);
        chk("end_latency",   32'(edges),     32'(TAPS + 1 + stalls));
        break;
      end
      chk("stream_in_ready",  32'(in_ready),  32'd0);
      chk("stream_busy",      32'(busy),      32'd1);
      chk("stream_tap_valid", 32'(tap_valid), 32'd1);
      if (abort_idx >= 0 && int'(tap_index) == abort_idx) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        tap_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        break;
      end
      chk("tap_index", 32'(tap_index), 32'(beat));
      chk("tap_data",  32'(tap_data),  32'(model_tap(beat)));
      chk("tap_first", 32'(tap_first), 32'(beat == 0));
      chk("tap_last",  32'(tap_last),  32'(beat == TAPS-1));
      if (beat < TAPS) cap[beat] = tap_data;
      rdy = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (int'(tap_index) == stall_idx && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      tap_ready = rdy;
      if (rdy) begin
        beat++;
        if (beat == TAPS) done = 1'b1;
      end else begin
        stalls++;
      end
    end
    tap_ready = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] val, input bit hold, input int stall_idx,
                      input int stall_len, input bit rnd_bp, input int abort_idx);
    int w = 0;
    while (in_ready !== 1'b1) begin
      @(posedge clk); #1; w++;
      if (w > 300) begin
        chk("ready_timeout", 32'(w), 32'd300);
        return;
      end
    end
    in_valid = 1'b1;
    in_data  = val;
    @(posedge clk);
    hist.push_front(val);
    if (hist.size() > TAPS) void'(hist.pop_back());
    #1;
    in_valid = hold;
    in_data  = hold ? 16'h7FFF : $urandom_range(0, 16'hFFFF);
    chk("load_tap_valid", 32'(tap_valid), 32'd0);
    chk("load_busy",      32'(busy),      32'd1);
    chk("load_in_ready",  32'(in_ready),  32'd0);
    tap_ready = 1'($urandom_range(0, 1));
    collect(stall_idx, stall_len, rnd_bp, abort_idx);
  endtask

  initial begin
    #1;
    check_reset_outputs("por");
    do_reset();

    // Impulse into an empty line.
    push(16'h0100, 1'b0, -1, 0, 1'b0, -1);
    chk("impulse_beat0", 32'(cap[0]), 32'h0100);
    chk("impulse_beat1", 32'(cap[1]), 32'h0);

    do_reset();
    push(16'd1, 1'b0, -1, 0, 1'b0, -1);
    push(16'd2, 1'b0, -1, 0, 1'b0, -1);
    push(16'd3, 1'b0, -1, 0, 1'b0, -1);
    chk("seq_k0", 32'(cap[0]), 32'd3);
    chk("seq_k1", 32'(cap[1]), 32'd2);
    chk("seq_k2", 32'(cap[2]), 32'd1);
    chk("seq_k3", 32'(cap[3]), 32'd0);

    // Five-cycle stall at tap 10.
    push(16'h1234, 1'b0, 10, 5, 1'b0, -1);

    // Wrap the newest pointer past 63.
    do_reset();
    for (int i = 0; i < 70; i++) push(16'(i), 1'b0, -1, 0, 1'((i % 2) != 0), -1);
    chk("wrap_k0",  32'(cap[0]),  32'd69);
    chk("wrap_k63", 32'(cap[63]), 32'd6);

    // Source holds 0x7FFF throughout a stream; it must be taken exactly once.
    push(16'(unsigned'($urandom)), 1'b1, -1, 0, 1'b1, -1);
    push(16'h7FFF, 1'b0, -1, 0, 1'b0, -1);
    chk("hold_k0", 32'(cap[0]), 32'h7FFF);
    chk("hold_k1", 32'(cap[1]), 32'(hist[1]));

    for (int i = 0; i < 6; i++) push(16'(unsigned'($urandom)), 1'b0, -1, 0, 1'b1, -1);

    // Reset mid-stream, then restart from a zeroed history.
    push(16'(unsigned'($urandom)), 1'b0, -1, 0, 1'b0, 30);
    push(16'h0005, 1'b0, -1, 0, 1'b1, -1);
    chk("post_rst_k0",  32'(cap[0]),  32'h5);
    chk("post_rst_k1",  32'(cap[1]),  32'h0);
    chk("post_rst_k63", 32'(cap[63]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
